// File: rtl/hazard_pkg.sv
// hazard_pkg: shared multiply-sequencer state type and latency constants
package hazard_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, WB} mul_state_t;
  localparam int MUL_LAT_DEF = 4;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: tracks one in-flight multiply and raises its write-back pulse MUL_LAT cycles after start
module mul_sequencer
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  E_IsMul,
  input  logic [DATA_WIDTH-1:0] E_Rd,
  output mul_state_t            state,
  output logic                  Mul_Start,
  output logic                  Mul_Busy,
  output logic                  W_RegMul,
  output logic [DATA_WIDTH-1:0] W_Rd_Mul
);
  logic [CNT_W-1:0] cnt, cnt_nx;
  mul_state_t state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      W_Rd_Mul <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (Mul_Start) W_Rd_Mul <= E_Rd;
    end
  // cnt counts down to zero and holds there; only IDLE reloads it
  always_comb begin
    Mul_Start = (state == IDLE) && E_IsMul && !rst;
    Mul_Busy  = state != IDLE;
    W_RegMul  = state == WB;
    state_nx  = state == IDLE ? (Mul_Start ? BUSY : IDLE)
              : state == BUSY ? (cnt == '0 ? WB : BUSY) : IDLE;
    cnt_nx    = Mul_Start ? CNT_W'(MUL_LAT - 2)
              : (state == BUSY && cnt != '0) ? cnt - 4'd1 : cnt;
  end
endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: decode-stage stall/flush generation for load-use, decode-branch and multiplier hazards
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] D_Rs1,
  input  logic [DATA_WIDTH-1:0] D_Rs2,
  input  logic [DATA_WIDTH-1:0] D_Rd,
  input  logic                  D_UseRs2,
  input  logic                  D_Branch,
  input  logic                  D_RegWrite,
  input  logic                  D_IsMul,
  input  logic [DATA_WIDTH-1:0] E_Rd,
  input  logic                  E_RegWrite,
  input  logic                  E_MemRead,
  input  logic                  E_IsMul,
  input  logic [DATA_WIDTH-1:0] M_Rd,
  input  logic                  M_MemRead,
  output logic                  Stall_PC,
  output logic                  Stall_IFID,
  output logic                  Flush_IDEX,
  output logic                  Mul_Start,
  output logic                  Mul_Busy,
  output logic                  W_RegMul,
  output logic [DATA_WIDTH-1:0] W_Rd_Mul
);
  mul_state_t state;
  logic e_hit, m_hit, w_hit, stall;
  mul_sequencer #(.DATA_WIDTH(DATA_WIDTH), .MUL_LAT(MUL_LAT)) u_seq (
    .clk(clk), .rst(rst), .E_IsMul(E_IsMul), .E_Rd(E_Rd), .state(state),
    .Mul_Start(Mul_Start), .Mul_Busy(Mul_Busy), .W_RegMul(W_RegMul), .W_Rd_Mul(W_Rd_Mul)
  );
  // register 0 is hardwired, so a zero destination never matches
  always_comb begin
    e_hit = E_Rd != '0 && (E_Rd == D_Rs1 || (D_UseRs2 && E_Rd == D_Rs2));
    m_hit = M_Rd != '0 && (M_Rd == D_Rs1 || (D_UseRs2 && M_Rd == D_Rs2));
    w_hit = W_Rd_Mul != '0 && (W_Rd_Mul == D_Rs1 || (D_UseRs2 && W_Rd_Mul == D_Rs2));
    stall = (E_MemRead && e_hit)
         || (D_Branch && E_RegWrite && e_hit)
         || (D_Branch && M_MemRead && m_hit)
         || (D_IsMul && Mul_Busy)
         || (state == BUSY && w_hit)
         || (state == BUSY && D_RegWrite && D_Rd == W_Rd_Mul && D_Rd != '0);
    Stall_PC   = stall;
    Stall_IFID = stall;
    Flush_IDEX = stall;
  end
endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed checks of hazard stalls and multiply sequencing
module tb_hazard_scheduler;
  localparam int W = 5;
  logic clk = 0, rst = 1;
  logic [W-1:0] D_Rs1, D_Rs2, D_Rd, E_Rd, M_Rd;
  logic D_UseRs2, D_Branch, D_RegWrite, D_IsMul, E_RegWrite, E_MemRead, E_IsMul, M_MemRead;
  logic Stall_PC, Stall_IFID, Flush_IDEX, Mul_Start, Mul_Busy, W_RegMul;
  logic [W-1:0] W_Rd_Mul;
  logic s2_pc, s2_ifid, s2_flush, ms2, mb2, wr2;
  logic [W-1:0] wrd2;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  hazard_scheduler #(.DATA_WIDTH(W), .MUL_LAT(4)) dut (
    .clk(clk), .rst(rst), .D_Rs1(D_Rs1), .D_Rs2(D_Rs2), .D_Rd(D_Rd), .D_UseRs2(D_UseRs2),
    .D_Branch(D_Branch), .D_RegWrite(D_RegWrite), .D_IsMul(D_IsMul), .E_Rd(E_Rd),
    .E_RegWrite(E_RegWrite), .E_MemRead(E_MemRead), .E_IsMul(E_IsMul), .M_Rd(M_Rd),
    .M_MemRead(M_MemRead), .Stall_PC(Stall_PC), .Stall_IFID(Stall_IFID), .Flush_IDEX(Flush_IDEX),
    .Mul_Start(Mul_Start), .Mul_Busy(Mul_Busy), .W_RegMul(W_RegMul), .W_Rd_Mul(W_Rd_Mul)
  );

  hazard_scheduler #(.DATA_WIDTH(W), .MUL_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .D_Rs1(D_Rs1), .D_Rs2(D_Rs2), .D_Rd(D_Rd), .D_UseRs2(D_UseRs2),
    .D_Branch(D_Branch), .D_RegWrite(D_RegWrite), .D_IsMul(D_IsMul), .E_Rd(E_Rd),
    .E_RegWrite(E_RegWrite), .E_MemRead(E_MemRead), .E_IsMul(E_IsMul), .M_Rd(M_Rd),
    .M_MemRead(M_MemRead), .Stall_PC(s2_pc), .Stall_IFID(s2_ifid), .Flush_IDEX(s2_flush),
    .Mul_Start(ms2), .Mul_Busy(mb2), .W_RegMul(wr2), .W_Rd_Mul(wrd2)
  );

  task automatic clear_inputs();
    {D_Rs1, D_Rs2, D_Rd, E_Rd, M_Rd} = '0;
    {D_UseRs2, D_Branch, D_RegWrite, D_IsMul, E_RegWrite, E_MemRead, E_IsMul, M_MemRead} = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    E_IsMul = 1;
    E_Rd = 9;
    #2;
    total++;
    if ({Mul_Start, Mul_Busy, W_RegMul} !== 3'b000)
      $display("FAIL reset_ctrl start/busy/wb=%b expected 000", {Mul_Start, Mul_Busy, W_RegMul});
    else pass++;
    total++;
    if (W_Rd_Mul !== 5'd0) $display("FAIL reset_rd W_Rd_Mul=%0d expected 0", W_Rd_Mul);
    else pass++;
    E_IsMul = 0;
    cyc();
    rst = 0;
    cyc();
    total++;
    if ({Mul_Busy, W_RegMul, Stall_PC} !== 3'b000)
      $display("FAIL reset_release busy/wb/stall=%b expected 000", {Mul_Busy, W_RegMul, Stall_PC});
    else pass++;
  endtask

  task automatic test_load_use();
    clear_inputs();
    E_MemRead = 1; E_Rd = 5; D_Rs1 = 5;
    #1;
    total++;
    if ({Stall_PC, Stall_IFID, Flush_IDEX} !== 3'b111)
      $display("FAIL load_use_rs1 stall=%b expected 111", {Stall_PC, Stall_IFID, Flush_IDEX});
    else pass++;
    E_Rd = 0; D_Rs1 = 0;
    #1;
    total++;
    if ({Stall_PC, Stall_IFID, Flush_IDEX} !== 3'b000)
      $display("FAIL load_use_r0 stall=%b expected 000", {Stall_PC, Stall_IFID, Flush_IDEX});
    else pass++;
    E_Rd = 5; D_Rs1 = 1; D_Rs2 = 5; D_UseRs2 = 0;
    #1;
    total++;
    if (Stall_PC !== 1'b0) $display("FAIL load_use_rs2_unused stall=%b expected 0", Stall_PC);
    else pass++;
    D_UseRs2 = 1;
    #1;
    total++;
    if (Stall_PC !== 1'b1) $display("FAIL load_use_rs2 stall=%b expected 1", Stall_PC);
    else pass++;
    cyc();
    E_MemRead = 0;
    #1;
    total++;
    if ({Stall_PC, Stall_IFID, Flush_IDEX} !== 3'b000)
      $display("FAIL load_use_done stall=%b expected 000", {Stall_PC, Stall_IFID, Flush_IDEX});
    else pass++;
  endtask

  task automatic test_branch();
    clear_inputs();
    D_Branch = 1; D_Rs2 = 7; D_UseRs2 = 1; M_MemRead = 1; M_Rd = 7;
    #1;
    total++;
    if (Flush_IDEX !== 1'b1) $display("FAIL branch_load stall=%b expected 1", Flush_IDEX);
    else pass++;
    M_MemRead = 0; E_RegWrite = 1; E_Rd = 7;
    #1;
    total++;
    if (Stall_IFID !== 1'b1) $display("FAIL branch_alu stall=%b expected 1", Stall_IFID);
    else pass++;
    D_Branch = 0;
    #1;
    total++;
    if (Stall_PC !== 1'b0) $display("FAIL alu_no_branch stall=%b expected 0", Stall_PC);
    else pass++;
    D_Branch = 1; M_MemRead = 1; M_Rd = 0; E_RegWrite = 0; D_Rs2 = 0;
    #1;
    total++;
    if (Stall_PC !== 1'b0) $display("FAIL branch_load_r0 stall=%b expected 0", Stall_PC);
    else pass++;
    clear_inputs();
    cyc();
  endtask

  task automatic test_mul_timing();
    logic [3:0] exp_busy = 4'b1111;
    clear_inputs();
    E_IsMul = 1; E_Rd = 9;
    #1;
    total++;
    if ({Mul_Start, Mul_Busy, W_RegMul} !== 3'b100)
      $display("FAIL mul_c0 start/busy/wb=%b expected 100", {Mul_Start, Mul_Busy, W_RegMul});
    else pass++;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      E_IsMul = 0;
      #1;
      total++;
      if ({Mul_Start, Mul_Busy, W_RegMul} !== {1'b0, c <= 4, c == 4})
        $display("FAIL mul_c%0d start/busy/wb=%b expected %b", c, {Mul_Start, Mul_Busy, W_RegMul},
                 {1'b0, c <= 4, c == 4});
      else pass++;
      if (c == 4) begin
        total++;
        if (W_Rd_Mul !== 5'd9) $display("FAIL mul_wb_rd W_Rd_Mul=%0d expected 9", W_Rd_Mul);
        else pass++;
      end
    end
    if (exp_busy == 4'b0) $display("unreachable");
  endtask

  task automatic test_min_latency();
    clear_inputs();
    E_IsMul = 1; E_Rd = 6;
    #1;
    total++;
    if (ms2 !== 1'b1) $display("FAIL lat2_start got=%b expected 1", ms2);
    else pass++;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      E_IsMul = 0;
      #1;
      total++;
      if ({mb2, wr2} !== {c <= 2, c == 2})
        $display("FAIL lat2_c%0d busy/wb=%b expected %b", c, {mb2, wr2}, {c <= 2, c == 2});
      else pass++;
    end
    cyc();
    cyc();
  endtask

  task automatic test_mul_deps();
    clear_inputs();
    E_IsMul = 1; E_Rd = 9;
    cyc();
    E_IsMul = 0; D_Rs1 = 9;
    #1;
    total++;
    if (Stall_PC !== 1'b1) $display("FAIL mul_raw_busy stall=%b expected 1", Stall_PC);
    else pass++;
    cyc();
    D_Rs1 = 0; D_IsMul = 1;
    #1;
    total++;
    if (Stall_PC !== 1'b1) $display("FAIL mul_struct_busy stall=%b expected 1", Stall_PC);
    else pass++;
    cyc();
    D_IsMul = 0; D_RegWrite = 1; D_Rd = 9;
    #1;
    total++;
    if (Stall_PC !== 1'b1) $display("FAIL mul_waw_9 stall=%b expected 1", Stall_PC);
    else pass++;
    cyc();
    D_RegWrite = 0; D_Rs1 = 9;
    #1;
    total++;
    if ({W_RegMul, Stall_PC} !== 2'b10) $display("FAIL mul_raw_wb wb/stall=%b expected 10", {W_RegMul, Stall_PC});
    else pass++;
    D_IsMul = 1;
    #1;
    total++;
    if (Stall_PC !== 1'b1) $display("FAIL mul_struct_wb stall=%b expected 1", Stall_PC);
    else pass++;
    cyc();
    #1;
    total++;
    if ({Mul_Busy, Stall_PC} !== 2'b00) $display("FAIL mul_idle busy/stall=%b expected 00", {Mul_Busy, Stall_PC});
    else pass++;
    clear_inputs();
  endtask

  task automatic test_waw();
    clear_inputs();
    E_IsMul = 1; E_Rd = 3;
    cyc();
    E_IsMul = 0; D_RegWrite = 1; D_Rd = 3;
    #1;
    total++;
    if (Stall_PC !== 1'b1) $display("FAIL waw_match stall=%b expected 1", Stall_PC);
    else pass++;
    D_Rd = 4;
    #1;
    total++;
    if (Stall_PC !== 1'b0) $display("FAIL waw_other stall=%b expected 0", Stall_PC);
    else pass++;
    clear_inputs();
    repeat (5) cyc();
    E_IsMul = 1; E_Rd = 0;
    cyc();
    E_IsMul = 0; D_RegWrite = 1; D_Rd = 0; D_Rs1 = 0;
    #1;
    total++;
    if ({Mul_Busy, Stall_PC} !== 2'b10) $display("FAIL mul_r0 busy/stall=%b expected 10", {Mul_Busy, Stall_PC});
    else pass++;
    clear_inputs();
    repeat (5) cyc();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    E_IsMul = 1; E_Rd = 9;
    cyc();
    E_IsMul = 0;
    cyc();
    rst = 1;
    #1;
    total++;
    if ({Mul_Busy, W_RegMul} !== 2'b00 || W_Rd_Mul !== 5'd0)
      $display("FAIL reset_mid busy/wb=%b rd=%0d expected 00 rd 0", {Mul_Busy, W_RegMul}, W_Rd_Mul);
    else pass++;
    #2;
    rst = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      total++;
      if ({Mul_Busy, W_RegMul} !== 2'b00)
        $display("FAIL reset_mid_after%0d busy/wb=%b expected 00", c, {Mul_Busy, W_RegMul});
      else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mul_timing();
    test_min_latency();
    test_mul_deps();
    test_waw();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
